nanosoc_busmatrix_input_hold: RTL

Per-master address-phase holding stage of the nanosoc bus matrix, between an AHB-Lite master port and the decoder/output stages whose unselected path ends in the default slave. It captures an address phase the output stage cannot accept that cycle and replays it from registers until granted, inserting wait states on the master. It returns data-phase ready/response from the downstream stage, including the default slave's two-cycle ERROR, to the master.

---
 rtl/nanosoc_busmatrix_input_hold.sv | 122 ++++++++++++
 1 files changed

// File: rtl/nanosoc_busmatrix_input_hold.sv
// Per-master AHB-Lite address-phase hold stage: replays a refused address phase from registers
// while stalling the master; data-phase ready/response pass back. Option: NANOSOC_BUSMATRIX_HOLD_SEQ2NONSEQ_EN
module nanosoc_busmatrix_input_hold #(
  parameter int ADDR_W = 32,
  parameter int PROT_W = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [PROT_W-1:0] HPROTS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              HSELM,
  output logic [ADDR_W-1:0] HADDRM,
  output logic [1:0]        HTRANSM,
  output logic              HWRITEM,
  output logic [2:0]        HSIZEM,
  output logic [2:0]        HBURSTM,
  output logic [PROT_W-1:0] HPROTM,
  input  logic              ACCEPTM,
  input  logic              DATAACTM,
  input  logic              READYM,
  input  logic [1:0]        RESPM
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  typedef enum logic {IDLE_PASS = 1'b0, HELD = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_new_req;
  logic              w_capture;
  logic [1:0]        w_held_trans;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_trans;
  logic              r_write;
  logic [2:0]        r_size;
  logic [2:0]        r_burst;
  logic [PROT_W-1:0] r_prot;

  assign w_new_req = HSELS & HREADYS & HTRANSS[1];
  assign w_capture = (r_state == IDLE_PASS) & w_new_req & ~ACCEPTM;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= IDLE_PASS;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE_PASS: if (w_capture) w_state_nxt = HELD;
      HELD:      if (ACCEPTM)   w_state_nxt = IDLE_PASS;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr  <= '0;
      r_trans <= TRANS_IDLE;
      r_write <= 1'b0;
      r_size  <= '0;
      r_burst <= '0;
      r_prot  <= '0;
    end else if (w_capture) begin
      r_addr  <= HADDRS;
      r_trans <= HTRANSS;
      r_write <= HWRITES;
      r_size  <= HSIZES;
      r_burst <= HBURSTS;
      r_prot  <= HPROTS;
    end
  end

`ifdef NANOSOC_BUSMATRIX_HOLD_SEQ2NONSEQ_EN
  // A replayed beat may lose arbitration continuity, so restart it as NONSEQ.
  assign w_held_trans = (r_trans == TRANS_SEQ) ? TRANS_NONSEQ : r_trans;
`else
  assign w_held_trans = r_trans;
`endif

  always_comb begin
    HSELM      = w_new_req;
    HADDRM     = HADDRS;
    HTRANSM    = HSELS ? HTRANSS : TRANS_IDLE;
    HWRITEM    = HWRITES;
    HSIZEM     = HSIZES;
    HBURSTM    = HBURSTS;
    HPROTM     = HPROTS;
    HREADYOUTS = DATAACTM ? READYM : 1'b1;
    HRESPS     = DATAACTM ? RESPM : RESP_OKAY;
    if (r_state == HELD) begin
      HSELM      = 1'b1;
      HADDRM     = r_addr;
      HTRANSM    = w_held_trans;
      HWRITEM    = r_write;
      HSIZEM     = r_size;
      HBURSTM    = r_burst;
      HPROTM     = r_prot;
      HREADYOUTS = 1'b0;
      HRESPS     = RESP_OKAY;
    end
    // Keep the bus quiet while reset is held, whatever the master drives.
    if (!HRESETn) begin
      HSELM      = 1'b0;
      HTRANSM    = TRANS_IDLE;
      HREADYOUTS = 1'b1;
      HRESPS     = RESP_OKAY;
    end
  end

endmodule
